// File: rtl/rr_arbiter_locking.sv
// Registered round-robin arbiter with grant locking and per-requester beat quotas.
// An owner keeps its grant until it drops its request or uses up its quota.
module rr_arbiter_locking #(
  parameter int unsigned INPUTS   = 4,
  parameter int unsigned WEIGHT_W = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            req,
  input  logic                         beat,
  input  logic [INPUTS*WEIGHT_W-1:0]   weight,
  output logic [INPUTS-1:0]            grant,
  output logic                         grant_valid,
  output logic [$clog2(INPUTS)-1:0]    grant_idx
);

  localparam int unsigned IdxW = $clog2(INPUTS);
  typedef logic [IdxW-1:0] idx_t;
  localparam idx_t LastIdx = idx_t'(INPUTS - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               state_q, state_d;
  idx_t                 ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  cnt_q, cnt_d;
  logic [INPUTS-1:0]    grant_q, grant_d;
  idx_t                 idx_q, idx_d;
  logic                 valid_q, valid_d;

  logic                 sel_found;
  idx_t                 sel_idx;
  logic [WEIGHT_W-1:0]  cur_w;
  logic                 release_lock;

  // Modular add that wraps at INPUTS-1, correct for non-power-of-two sizes.
  function automatic idx_t wrap_add(idx_t base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= INPUTS) s = s - INPUTS;
    return idx_t'(s);
  endfunction

  // First requester at or above ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (!sel_found && req[wrap_add(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Quota of the current owner, sampled live every cycle.
  always_comb begin
    cur_w = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (idx_q == idx_t'(i)) cur_w = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign release_lock = !req[idx_q] ||
                        (beat && (cur_w != '0) && (cnt_q == cur_w - WEIGHT_W'(1)));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d          = StLocked;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          idx_d            = sel_idx;
          valid_d          = 1'b1;
          cnt_d            = '0;
        end
      end
      StLocked: begin
        if (release_lock) begin
          state_d = StIdle;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          cnt_d   = '0;
          ptr_d   = (idx_q == LastIdx) ? idx_t'(0) : idx_q + idx_t'(1);
        end else if (beat && (cnt_q != '1)) begin
          // Saturating so an unlimited (zero) quota never wraps the counter.
          cnt_d = cnt_q + WEIGHT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_locking.sv
// Directed bench for rr_arbiter_locking: vector table for rotation, quota and early
// release, plus hand sequences for async reset mid-lock and a 5-requester wrap.
module tb_rr_arbiter_locking;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        beat;
  logic [11:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_idx;

  logic [4:0]  req5;
  logic [14:0] weight5;
  logic [4:0]  grant5;
  logic        grant_valid5;
  logic [2:0]  grant_idx5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_locking #(.INPUTS(4), .WEIGHT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .beat        (beat),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  rr_arbiter_locking #(.INPUTS(5), .WEIGHT_W(3)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .req         (req5),
    .beat        (beat),
    .weight      (weight5),
    .grant       (grant5),
    .grant_valid (grant_valid5),
    .grant_idx   (grant_idx5)
  );

  typedef struct {
    logic [3:0]  req;
    logic        beat;
    logic [11:0] weight;
    logic [3:0]  g;
    logic [1:0]  idx;
    logic        v;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] idx,
                       input logic v);
    total++;
    if (grant !== g || grant_idx !== idx || grant_valid !== v) begin
      bad++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b, want grant=%b idx=%0d valid=%b",
               name, grant, grant_idx, grant_valid, g, idx, v);
    end
  endtask

  task automatic check5(input string name, input logic [4:0] g, input logic [2:0] idx,
                        input logic v);
    total++;
    if (grant5 !== g || grant_idx5 !== idx || grant_valid5 !== v) begin
      bad++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b, want grant=%b idx=%0d valid=%b",
               name, grant5, grant_idx5, grant_valid5, g, idx, v);
    end
  endtask

  initial begin
    // Fairness rotation, all quotas 1 (first grant comes from the reset sequence).
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0000, 2'd0, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0010, 2'd1, 1'b1});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0000, 2'd0, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0100, 2'd2, 1'b1});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0000, 2'd0, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b1000, 2'd3, 1'b1});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0000, 2'd0, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 12'h249, 4'b0001, 2'd0, 1'b1});
    vq.push_back('{4'b0000, 1'b0, 12'h249, 4'b0000, 2'd0, 1'b0}); // ptr -> 1
    // Quota lock: weight[2]=3.
    vq.push_back('{4'b0100, 1'b1, 12'h2C9, 4'b0100, 2'd2, 1'b1});
    vq.push_back('{4'b0100, 1'b1, 12'h2C9, 4'b0100, 2'd2, 1'b1});
    vq.push_back('{4'b0100, 1'b1, 12'h2C9, 4'b0100, 2'd2, 1'b1});
    vq.push_back('{4'b0100, 1'b1, 12'h2C9, 4'b0000, 2'd0, 1'b0});
    vq.push_back('{4'b0100, 1'b1, 12'h2C9, 4'b0100, 2'd2, 1'b1});
    vq.push_back('{4'b0100, 1'b1, 12'h2C9, 4'b0100, 2'd2, 1'b1});
    vq.push_back('{4'b0000, 1'b0, 12'h2C9, 4'b0000, 2'd0, 1'b0}); // ptr -> 3
    // Early release, weight[1]=0, contender 3 ignored while locked.
    vq.push_back('{4'b0010, 1'b1, 12'h241, 4'b0010, 2'd1, 1'b1});
    vq.push_back('{4'b1010, 1'b1, 12'h241, 4'b0010, 2'd1, 1'b1});
    vq.push_back('{4'b1010, 1'b1, 12'h241, 4'b0010, 2'd1, 1'b1});
    vq.push_back('{4'b1010, 1'b1, 12'h241, 4'b0010, 2'd1, 1'b1});
    vq.push_back('{4'b1010, 1'b1, 12'h241, 4'b0010, 2'd1, 1'b1});
    vq.push_back('{4'b1000, 1'b1, 12'h241, 4'b0000, 2'd0, 1'b0});
    vq.push_back('{4'b1000, 1'b1, 12'h241, 4'b1000, 2'd3, 1'b1});
    vq.push_back('{4'b0000, 1'b0, 12'h241, 4'b0000, 2'd0, 1'b0}); // ptr -> 0

    rst     = 1'b1;
    req     = 4'b1111;
    beat    = 1'b1;
    weight  = 12'h249;
    req5    = '0;
    weight5 = '0;
    #1;
    check("reset_async", 4'b0000, 2'd0, 1'b0);
    check5("reset_async5", 5'b00000, 3'd0, 1'b0);
    tick();
    check("reset_held", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    check("reset_first_grant", 4'b0001, 2'd0, 1'b1);

    foreach (vq[i]) begin
      req    = vq[i].req;
      beat   = vq[i].beat;
      weight = vq[i].weight;
      tick();
      check($sformatf("vec%0d", i), vq[i].g, vq[i].idx, vq[i].v);
    end

    // Async reset mid-lock with a stale pointer of 3 that must return to 0.
    beat   = 1'b0;
    weight = 12'h000;
    req    = 4'b0100;
    tick();
    check("lock2_a", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    check("rel2", 4'b0000, 2'd0, 1'b0);
    req = 4'b0100;
    tick();
    check("lock2_b", 4'b0100, 2'd2, 1'b1);
    tick();
    check("lock2_hold", 4'b0100, 2'd2, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_midlock_immediate", 4'b0000, 2'd0, 1'b0);
    #1;
    rst = 1'b0;
    req = 4'b1100;
    tick();
    check("rst_ptr_zero", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    check("rst_release", 4'b0000, 2'd0, 1'b0);

    // Five requesters: grant 3 moves ptr to 4, then wrap past 4 to 0.
    req5 = 5'b01000;
    tick();
    check5("w5_grant3", 5'b01000, 3'd3, 1'b1);
    req5 = 5'b00000;
    tick();
    check5("w5_release", 5'b00000, 3'd0, 1'b0);
    req5 = 5'b00011;
    tick();
    check5("w5_wrap", 5'b00001, 3'd0, 1'b1);
    req5 = 5'b10000;
    tick();
    check5("w5_rel0", 5'b00000, 3'd0, 1'b0);
    tick();
    check5("w5_grant4", 5'b10000, 3'd4, 1'b1);
    req5 = 5'b00011;
    tick();
    check5("w5_rel4", 5'b00000, 3'd0, 1'b0);
    tick();
    check5("w5_wrap4", 5'b00001, 3'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_locking.md
Name: rr_arbiter_locking

Overview:
- Registered, stateful round-robin arbiter with a rotating priority pointer and grant locking.
- Each grant is held for a multi-beat transfer and released when the owner drops its request or exhausts a per-requester beat quota.
- Sits in front of a shared resource such as a bus, memory port or output mux.
- Generalises the combinational round-robin arbiter:
  - it owns its own priority state;
  - it keeps a grant across cycles;
  - it has per-channel weighting.

Parameters:
- INPUTS, 4: number of requesters, >=2, need not be a power of two.
- WEIGHT_W, 3: width of each per-requester beat quota.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  INPUTS  request vector; bit i = requester i wants the resource.
- beat  in  1  one beat of the current owner's transfer completed this cycle.
- weight  in  INPUTS*WEIGHT_W  quota for requester i in slice [i*WEIGHT_W +: WEIGHT_W]; 0 = unlimited.
- grant  out  INPUTS  registered one-hot grant, or all-zero.
- grant_valid  out  1  registered; equals |grant.
- grant_idx  out  $clog2(INPUTS)  registered index of the owner; 0 when no grant.

Behaviour:
- Reset, asynchronous, applies regardless of current state:
  - grant=0, grant_valid=0, grant_idx=0.
  - Priority pointer ptr=0, beat counter cnt=0, state IDLE.
- States: IDLE, LOCKED.
- IDLE:
  - req==0: stay IDLE, outputs unchanged at zero.
  - req!=0: select the first set bit searching upward from ptr, wrapping INPUTS-1 -> 0.
  - At the next edge: grant=onehot(sel), grant_idx=sel, grant_valid=1, cnt=0, go LOCKED.
  - Latency: req seen in cycle n produces grant in cycle n+1.
- LOCKED: the release condition is any of:
  - (a) req[grant_idx]==0;
  - (b) beat==1, weight[grant_idx]!=0 and cnt==weight[grant_idx]-1.
- On release, at the edge:
  - grant=0, grant_valid=0, grant_idx=0, cnt=0.
  - ptr=(owner+1) mod INPUTS, wrapping at INPUTS-1 even when INPUTS is not a power of two.
  - Go IDLE.
- No release:
  - beat==1: cnt=cnt+1. cnt is WEIGHT_W bits and never exceeds weight-1 when weight!=0.
  - weight==0: cnt saturates at all-ones and never forces release.
  - beat==0: cnt holds.
  - grant holds.
- Release always costs exactly one idle cycle: there is no grant in the cycle after release. Re-arbitration happens in that IDLE cycle, so the next grant appears two cycles after the release condition.
- Requests from non-owners during LOCKED are ignored; their bits are not latched.
- Owner re-raising request after release:
  - It competes normally, with the lowest priority (ptr has moved past it).
  - It wins only if no other bit is set.
- beat while in IDLE has no effect.
- weight is sampled every cycle, not latched. A change mid-lock takes effect on the next comparison.
- A requester whose req is 0 is never granted. Its pointer slot is skipped, not consumed.
- Reset asserted mid-lock: grant clears immediately, without waiting for an edge. ptr returns to 0.
- grant is always one-hot or zero. grant_valid and grant_idx are always consistent with grant.

Test Plan:
- Reset sequencing:
  - Stimulus: assert rst with req=4'b1111, then deassert.
  - Response: grant=0 during reset. 1 cycle after release: grant=4'b0001, grant_idx=0.
- Fairness rotation:
  - Stimulus: weight all =1, req=4'b1111, beat=1 continuously.
  - Response: grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Quota lock:
  - Stimulus: weight[2]=3, req=4'b0100 held, beat=1 every cycle.
  - Response: grant=0100 for exactly 3 cycles, then 0000 for 1 cycle, then 0100 again.
- Early release and ignored contenders:
  - Stimulus: weight[1]=0, owner 1 holds req for 5 cycles while req[3] is raised at cycle 2, then req[1] drops.
  - Response: grant stays 0010 for all 5 cycles, 0000 next, then 1000.
- Wrap and skip:
  - Stimulus: INPUTS=5, ptr advanced to 4 by granting requester 3, then req=5'b00011.
  - Response: grant=00001 (wrap past 4, skip absent requester).
- Async reset mid-lock:
  - Stimulus: owner 2 locked, rst pulsed between edges.
  - Response: grant=0 immediately. After release, req=4'b1100 -> grant=0100 (ptr back to 0).
